// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the 8N1 UART engine:
//   - uart_state_e : state encoding used by both the TX and RX FSMs
//   - calc_div     : rounded clock divider for the oversampling baud tick
// -----------------------------------------------------------------------------
package uart_pkg;

  // Both FSMs walk the same four phases of a frame.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_e;

  // round(clk_freq / (baud * os)) using integer arithmetic.
  function automatic int calc_div(input int clk_freq, input int baud, input int os);
    int denom;
    denom = baud * os;
    return (clk_freq + denom / 2) / denom;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Free-running oversampling tick generator. o_tick is high for one i_clk cycle
// every DIV cycles, DIV = round(CLK_FREQ / (BAUD_RATE * OVERSAMPLING)).
// Ports:
//   i_clk   in  1  system clock, rising edge
//   i_reset in  1  asynchronous, active-high reset
//   o_tick  out 1  one-cycle baud tick
// -----------------------------------------------------------------------------
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD_RATE    = 19200,
  parameter int OVERSAMPLING = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_tick
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLING);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_tick;

  // Tick is registered so it is a clean one-cycle pulse; the period is still
  // exactly DIV because the counter wraps on the same edge that raises it.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == CW'(DIV - 1)) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
      r_tick <= 1'b0;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/uart_core.sv
// -----------------------------------------------------------------------------
// uart_core
// 8N1 UART engine: shared baud tick, transmitter and receiver. TX and RX run
// independently and may be active at the same time.
// Handshake: i_tx_start is a one-cycle request, accepted only when TX is idle
// (requests while busy are dropped); o_tx_done / o_rx_done are one-cycle
// completion pulses with no back-pressure.
// Ports:
//   i_clk      in  1        system clock, rising edge
//   i_reset    in  1        asynchronous, active-high reset
//   i_tx_data  in  NB_DATA  byte to send, sampled with i_tx_start
//   i_tx_start in  1        start request (ignored while TX busy)
//   i_rx       in  1        serial input, idle high
//   o_tx       out 1        serial output, idle high
//   o_tx_done  out 1        pulse at the end of the stop bit
//   o_rx_data  out NB_DATA  last good received byte
//   o_rx_done  out 1        pulse when o_rx_data updates
//   o_tick     out 1        baud tick, for observation
// -----------------------------------------------------------------------------
module uart_core
  import uart_pkg::*;
#(
  parameter int NB_DATA      = 8,
  parameter int BAUD_RATE    = 19200,
  parameter int CLK_FREQ     = 50_000_000,
  parameter int OVERSAMPLING = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_tx_data,
  input  logic               i_tx_start,
  input  logic               i_rx,
  output logic               o_tx,
  output logic               o_tx_done,
  output logic [NB_DATA-1:0] o_rx_data,
  output logic               o_rx_done,
  output logic               o_tick
);

  localparam int TCW = $clog2(OVERSAMPLING);
  localparam int BCW = $clog2(NB_DATA);
  localparam logic [TCW-1:0] TICK_LAST = TCW'(OVERSAMPLING - 1);
  localparam logic [TCW-1:0] TICK_MID  = TCW'(OVERSAMPLING / 2 - 1);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(NB_DATA - 1);

  logic w_tick;

  uart_baud_gen #(
    .CLK_FREQ    (CLK_FREQ),
    .BAUD_RATE   (BAUD_RATE),
    .OVERSAMPLING(OVERSAMPLING)
  ) u_baud_gen (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .o_tick (w_tick)
  );

  assign o_tick = w_tick;

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  uart_state_e        r_tx_state;
  logic [TCW-1:0]     r_tx_tick_cnt;
  logic [BCW-1:0]     r_tx_bit_cnt;
  logic [NB_DATA-1:0] r_tx_shift;
  logic               r_tx;
  logic               r_tx_done;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_tx_state    <= S_IDLE;
      r_tx_tick_cnt <= '0;
      r_tx_bit_cnt  <= '0;
      r_tx_shift    <= '0;
      r_tx          <= 1'b1;
      r_tx_done     <= 1'b0;
    end else begin
      r_tx_done <= 1'b0;
      case (r_tx_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (i_tx_start) begin
            r_tx_shift    <= i_tx_data;
            r_tx_tick_cnt <= '0;
            r_tx          <= 1'b0;
            r_tx_state    <= S_START;
          end
        end
        S_START: begin
          if (w_tick) begin
            if (r_tx_tick_cnt == TICK_LAST) begin
              r_tx_tick_cnt <= '0;
              r_tx_bit_cnt  <= '0;
              r_tx          <= r_tx_shift[0];
              r_tx_state    <= S_DATA;
            end else begin
              r_tx_tick_cnt <= r_tx_tick_cnt + 1'b1;
            end
          end
        end
        S_DATA: begin
          if (w_tick) begin
            if (r_tx_tick_cnt == TICK_LAST) begin
              r_tx_tick_cnt <= '0;
              if (r_tx_bit_cnt == BIT_LAST) begin
                r_tx       <= 1'b1;
                r_tx_state <= S_STOP;
              end else begin
                // Next bit is shift[1] because the shift happens on this edge.
                r_tx_bit_cnt <= r_tx_bit_cnt + 1'b1;
                r_tx         <= r_tx_shift[1];
                r_tx_shift   <= r_tx_shift >> 1;
              end
            end else begin
              r_tx_tick_cnt <= r_tx_tick_cnt + 1'b1;
            end
          end
        end
        S_STOP: begin
          if (w_tick) begin
            if (r_tx_tick_cnt == TICK_LAST) begin
              r_tx_tick_cnt <= '0;
              r_tx_done     <= 1'b1;
              r_tx_state    <= S_IDLE;
            end else begin
              r_tx_tick_cnt <= r_tx_tick_cnt + 1'b1;
            end
          end
        end
        default: r_tx_state <= S_IDLE;
      endcase
    end
  end

  assign o_tx      = r_tx;
  assign o_tx_done = r_tx_done;

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  logic               r_rx_meta;
  logic               r_rx_sync;
  uart_state_e        r_rx_state;
  logic [TCW-1:0]     r_rx_tick_cnt;
  logic [BCW-1:0]     r_rx_bit_cnt;
  logic [NB_DATA-1:0] r_rx_shift;
  logic [NB_DATA-1:0] r_rx_data;
  logic               r_rx_done;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rx_state    <= S_IDLE;
      r_rx_tick_cnt <= '0;
      r_rx_bit_cnt  <= '0;
      r_rx_shift    <= '0;
      r_rx_data     <= '0;
      r_rx_done     <= 1'b0;
    end else begin
      r_rx_done <= 1'b0;
      case (r_rx_state)
        S_IDLE: begin
          if (!r_rx_sync) begin
            r_rx_tick_cnt <= '0;
            r_rx_state    <= S_START;
          end
        end
        S_START: begin
          // Re-check the line at mid start bit: from here on every sample
          // lands OVERSAMPLING ticks later, i.e. mid-bit.
          if (w_tick) begin
            if (r_rx_tick_cnt == TICK_MID) begin
              r_rx_tick_cnt <= '0;
              r_rx_bit_cnt  <= '0;
              r_rx_state    <= r_rx_sync ? S_IDLE : S_DATA;
            end else begin
              r_rx_tick_cnt <= r_rx_tick_cnt + 1'b1;
            end
          end
        end
        S_DATA: begin
          if (w_tick) begin
            if (r_rx_tick_cnt == TICK_LAST) begin
              r_rx_tick_cnt <= '0;
              // LSB arrives first, so shift in from the MSB side.
              r_rx_shift    <= {r_rx_sync, r_rx_shift[NB_DATA-1:1]};
              if (r_rx_bit_cnt == BIT_LAST) begin
                r_rx_state <= S_STOP;
              end else begin
                r_rx_bit_cnt <= r_rx_bit_cnt + 1'b1;
              end
            end else begin
              r_rx_tick_cnt <= r_rx_tick_cnt + 1'b1;
            end
          end
        end
        S_STOP: begin
          if (w_tick) begin
            if (r_rx_tick_cnt == TICK_LAST) begin
              r_rx_tick_cnt <= '0;
              // A low stop bit is a framing error: drop the byte silently.
              if (r_rx_sync) begin
                r_rx_data <= r_rx_shift;
                r_rx_done <= 1'b1;
              end
              r_rx_state <= S_IDLE;
            end else begin
              r_rx_tick_cnt <= r_rx_tick_cnt + 1'b1;
            end
          end
        end
        default: r_rx_state <= S_IDLE;
      endcase
    end
  end

  assign o_rx_data = r_rx_data;
  assign o_rx_done = r_rx_done;

endmodule

// File: tb/tb_uart_core.sv
// -----------------------------------------------------------------------------
// tb_uart_core
// Loopback bench for uart_core. A fast instance (divider 2) carries the frame
// tests; a default-parameter instance checks reset values and the 163-clock
// tick period.
// -----------------------------------------------------------------------------
module tb_uart_core;

  localparam int NB       = 8;
  localparam int OS       = 16;
  localparam int F_DIV    = 2;    // 32 MHz / (1 Mbit/s * 16)
  localparam int D_DIV    = 163;  // round(50 MHz / (19200 * 16))
  localparam int BIT_CLKS = OS * F_DIV;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;  // 50 MHz

  // ---------------- DUT signals ----------------
  logic [NB-1:0] tx_data;
  logic          tx_start;
  logic          force_en;
  logic          force_val;
  logic          rx_line;
  logic          f_tx, f_tx_done, f_rx_done, f_tick;
  logic [NB-1:0] f_rx_data;
  logic          d_tx, d_tx_done, d_rx_done, d_tick;
  logic [NB-1:0] d_rx_data;

  // Loopback unless the bench takes over the line.
  assign rx_line = force_en ? force_val : f_tx;

  uart_core #(
    .NB_DATA(NB), .BAUD_RATE(1_000_000), .CLK_FREQ(32_000_000), .OVERSAMPLING(OS)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_tx_data(tx_data), .i_tx_start(tx_start),
    .i_rx(rx_line), .o_tx(f_tx), .o_tx_done(f_tx_done), .o_rx_data(f_rx_data),
    .o_rx_done(f_rx_done), .o_tick(f_tick)
  );

  uart_core dut_def (
    .i_clk(clk), .i_reset(rst), .i_tx_data(8'h00), .i_tx_start(1'b0),
    .i_rx(d_tx), .o_tx(d_tx), .o_tx_done(d_tx_done), .o_rx_data(d_rx_data),
    .o_rx_done(d_rx_done), .o_tick(d_tick)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [NB-1:0] exp_q[$];
  logic [NB-1:0] last_rx;

  // Pulse monitor on the fast instance.
  int   rx_rise = 0, rx_hi = 0, tx_rise = 0, tx_hi = 0;
  logic prev_rx = 1'b0, prev_tx = 1'b0;
  always @(negedge clk) begin
    if (f_rx_done) rx_hi++;
    if (f_rx_done && !prev_rx) rx_rise++;
    if (f_tx_done) tx_hi++;
    if (f_tx_done && !prev_tx) tx_rise++;
    prev_rx = f_rx_done;
    prev_tx = f_tx_done;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Start a byte on the current negedge and wait for its o_tx_done. Returns on
  // the negedge that sees the pulse, so the next call starts 1 clk later.
  task automatic send_lb(input logic [NB-1:0] b);
    int n;
    int rx0;
    logic [NB-1:0] e;
    rx0 = rx_rise;
    exp_q.push_back(b);
    tx_data  = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    n = 0;
    while (!f_tx_done && n < 12 * BIT_CLKS) begin
      @(negedge clk);
      n++;
    end
    check("lb_tx_done_seen", 32'(f_tx_done), 32'd1);
    e = exp_q.pop_front();
    check("lb_rx_byte", 32'(f_rx_data), 32'(e));
    check("lb_rx_pulses", 32'(rx_rise - rx0), 32'd1);
    last_rx = e;
  endtask

  // Drive a complete frame onto i_rx directly, with a chosen stop bit level.
  task automatic drive_frame(input logic [NB-1:0] b, input logic stop_bit);
    force_en  = 1'b1;
    force_val = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < NB; i++) begin
      force_val = b[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    force_val = stop_bit;
    repeat (BIT_CLKS) @(negedge clk);
    force_val = 1'b1;
    repeat (3 * BIT_CLKS) @(negedge clk);
    force_en = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, k, len, rx0, rxh0, tx0, txh0;
    logic [NB-1:0] a5;
    a5        = 8'hA5;
    last_rx   = '0;
    tx_data   = '0;
    tx_start  = 1'b0;
    force_en  = 1'b0;
    force_val = 1'b1;

    // Reset values, both instances.
    #100;
    check("rst_tx", 32'(f_tx), 32'd1);
    check("rst_tx_done", 32'(f_tx_done), 32'd0);
    check("rst_rx_done", 32'(f_rx_done), 32'd0);
    check("rst_rx_data", 32'(f_rx_data), 32'd0);
    check("rst_tick", 32'(f_tick), 32'd0);
    check("rst_def_tx", 32'(d_tx), 32'd1);
    check("rst_def_rx_data", 32'(d_rx_data), 32'd0);
    check("rst_def_dones", 32'({d_tx_done, d_rx_done}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Tick period / width on the default instance.
    n = 0;
    while (!d_tick && n < 400) begin @(negedge clk); n++; end
    check("def_tick_found", 32'(d_tick), 32'd1);
    for (int p = 0; p < 2; p++) begin
      @(negedge clk);
      check("def_tick_width", 32'(d_tick), 32'd0);
      n = 1;
      while (!d_tick && n < 400) begin @(negedge clk); n++; end
      check("def_tick_period", 32'(n), 32'(D_DIV));
    end
    // And the fast instance.
    n = 0;
    while (!f_tick && n < 10) begin @(negedge clk); n++; end
    @(negedge clk);
    check("fast_tick_width", 32'(f_tick), 32'd0);
    n = 1;
    while (!f_tick && n < 10) begin @(negedge clk); n++; end
    check("fast_tick_period", 32'(n), 32'(F_DIV));

    // Frame timing for 0xA5.
    @(negedge clk);
    rx0 = rx_rise; rxh0 = rx_hi; tx0 = tx_rise; txh0 = tx_hi;
    tx_data  = a5;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    n = 0;
    while (f_tx && n < 4) begin @(negedge clk); n++; end
    check("a5_start_low", 32'(f_tx), 32'd0);
    // Start bit ends on the 16th tick; the first tick lands 1..DIV clks in.
    len = 0;
    while (!f_tx && len < BIT_CLKS + 4) begin @(negedge clk); len++; end
    check("a5_start_len", 32'(len >= (OS - 1) * F_DIV + 1 && len <= BIT_CLKS), 32'd1);
    repeat (BIT_CLKS / 2) @(negedge clk);
    for (int i = 0; i < NB; i++) begin
      check($sformatf("a5_bit%0d", i), 32'(f_tx), 32'(a5[i]));
      repeat (BIT_CLKS) @(negedge clk);
    end
    check("a5_stop", 32'(f_tx), 32'd1);
    check("a5_no_done_mid_stop", 32'(tx_rise - tx0), 32'd0);
    n = 0;
    while (!f_tx_done && n < BIT_CLKS) begin @(negedge clk); n++; end
    check("a5_tx_done", 32'(f_tx_done), 32'd1);
    check("a5_rx_data", 32'(f_rx_data), 32'hA5);
    check("a5_rx_pulse_cnt", 32'(rx_rise - rx0), 32'd1);
    check("a5_rx_pulse_width", 32'(rx_hi - rxh0), 32'd1);
    @(negedge clk);
    check("a5_tx_done_width", 32'(f_tx_done), 32'd0);
    check("a5_idle_high", 32'(f_tx), 32'd1);
    check("a5_tx_done_cnt", 32'(tx_hi - txh0), 32'd1);
    last_rx = a5;

    // 100 random bytes, back to back.
    for (int i = 0; i < 100; i++) send_lb(8'($urandom_range(0, 255)));
    @(negedge clk);

    // Start request while busy is ignored.
    rx0 = rx_rise; tx0 = tx_rise;
    tx_data  = 8'h11;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (5 * BIT_CLKS) @(negedge clk);
    tx_data  = 8'h3C;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    tx_data  = '0;
    n = 0;
    while (!f_tx_done && n < 12 * BIT_CLKS) begin @(negedge clk); n++; end
    check("busy_tx_done", 32'(f_tx_done), 32'd1);
    check("busy_rx_data", 32'(f_rx_data), 32'h11);
    repeat (2 * 11 * BIT_CLKS) @(negedge clk);
    check("busy_one_frame", 32'(tx_rise - tx0), 32'd1);
    check("busy_one_rx", 32'(rx_rise - rx0), 32'd1);
    check("busy_line_idle", 32'(f_tx), 32'd1);
    check("busy_rx_held", 32'(f_rx_data), 32'h11);
    last_rx = 8'h11;

    // Glitch: line low for 5 ticks only.
    rx0 = rx_rise;
    force_en  = 1'b1;
    force_val = 1'b0;
    n = 0; k = 0;
    while (k < 5 && n < 20 * F_DIV) begin
      @(negedge clk);
      n++;
      if (f_tick) k++;
    end
    force_val = 1'b1;
    repeat (3 * BIT_CLKS) @(negedge clk);
    force_en = 1'b0;
    check("glitch_no_done", 32'(rx_rise - rx0), 32'd0);
    check("glitch_data_held", 32'(f_rx_data), 32'(last_rx));

    // Directly driven good frame, then one with a low stop bit.
    rx0 = rx_rise;
    drive_frame(8'h96, 1'b1);
    check("forced_good_done", 32'(rx_rise - rx0), 32'd1);
    check("forced_good_data", 32'(f_rx_data), 32'h96);
    last_rx = 8'h96;
    rx0 = rx_rise;
    drive_frame(8'h4B, 1'b0);
    check("framing_no_done", 32'(rx_rise - rx0), 32'd0);
    check("framing_data_held", 32'(f_rx_data), 32'(last_rx));

    // RX recovered to idle: a normal loopback byte still works.
    send_lb(8'($urandom_range(0, 255)));
    @(negedge clk);

    // Reset during the DATA phase of 0x5A (bit2 = 0 at this point).
    rx0 = rx_rise; tx0 = tx_rise;
    tx_data  = 8'h5A;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (3 * BIT_CLKS + 5) @(negedge clk);
    check("mfr_pre_low", 32'(f_tx), 32'd0);
    rst = 1'b1;
    #1;
    check("mfr_tx_high", 32'(f_tx), 32'd1);
    check("mfr_tx_done", 32'(f_tx_done), 32'd0);
    check("mfr_rx_done", 32'(f_rx_done), 32'd0);
    check("mfr_rx_data", 32'(f_rx_data), 32'd0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    check("mfr_no_tx_pulse", 32'(tx_rise - tx0), 32'd0);
    check("mfr_no_rx_pulse", 32'(rx_rise - rx0), 32'd0);
    check("mfr_stays_idle", 32'(f_tx), 32'd1);
    send_lb(8'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
